// File: rtl/seq_op_controller_pkg.sv
// Shared definitions for the multi-cycle arithmetic sequencer:
// control word layout, opcodes and FSM state encoding.
package seq_op_controller_pkg;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic clear_acc;
    logic add_en;
    logic sub_en;
    logic shift_en;
    logic restore_en;
    logic qbit_set;
  } control_signals_t;

  typedef enum logic [1:0] {
    OPC_MUL = 2'd0,
    OPC_DIV = 2'd1,
    OPC_ADD = 2'd2
  } opc_e;

  // First opcode value (zero-extended) that has no operation behind it
  localparam int OPC_ILLEGAL = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_FIX,
    ST_DONE
  } ctrl_state_t;

  localparam control_signals_t CTRL_IDLE = '0;

endpackage

// File: rtl/seq_op_controller_iter_counter.sv
// Iteration counter: clear, increment, saturate at WIDTH,
// flags the final iteration (count == WIDTH-1).
module iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < CNT_W'(WIDTH))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_op_controller.sv
// Sequencer for the MUL/DIV/ADD datapath: latches an opcode on start
// and emits one control word per cycle until a done pulse.
module seq_op_controller
  import seq_op_controller_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPC_W = 2,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OPC_W-1:0] opc_code,
  input  logic             lsb,
  input  logic             neg,
  output control_signals_t control,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter
);

  ctrl_state_t      state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             accept, illegal, is_mul, is_div;

  assign accept  = start & ~abort;
  assign illegal = int'(opc_q) >= OPC_ILLEGAL;
  assign is_mul  = int'(opc_q) == int'(OPC_MUL);
  assign is_div  = int'(opc_q) == int'(OPC_DIV);

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (iter),
    .last (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    control = CTRL_IDLE;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          opc_d   = opc_code;
        end
      end
      ST_LOAD: begin
        busy              = 1'b1;
        control.load_a    = 1'b1;
        control.load_b    = 1'b1;
        control.clear_acc = 1'b1;
        cnt_clr           = 1'b1;
        state_d = illegal ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (is_mul) begin
          control.shift_en = 1'b1;
          control.add_en   = lsb;
          cnt_inc          = 1'b1;
          state_d = cnt_last ? ST_DONE : ST_EXEC;
        end else if (is_div) begin
          control.shift_en = 1'b1;
          control.sub_en   = 1'b1;
          state_d          = ST_FIX;
        end else begin
          control.add_en = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_FIX: begin
        busy               = 1'b1;
        control.restore_en = neg;
        control.qbit_set   = ~neg;
        cnt_inc            = 1'b1;
        state_d = cnt_last ? ST_DONE : ST_EXEC;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = illegal;
        if (accept) begin
          state_d = ST_LOAD;
          opc_d   = opc_code;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every other transition, including a back-to-back start
    if (abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

endmodule

// File: tb/tb_seq_op_controller.sv
// Directed bench for seq_op_controller (WIDTH=8): MUL, DIV, ADD,
// illegal opcode, abort, async reset and back-to-back starts.
module tb_seq_op_controller;
  import seq_op_controller_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH+1);

  localparam logic [31:0] C_LOAD  = 32'hE0;
  localparam logic [31:0] C_SHIFT = 32'h04;
  localparam logic [31:0] C_ADD   = 32'h10;
  localparam logic [31:0] C_DIVX  = 32'h0C;
  localparam logic [31:0] C_REST  = 32'h02;
  localparam logic [31:0] C_QBIT  = 32'h01;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [1:0]       opc_code;
  logic             lsb;
  logic             neg;
  control_signals_t control;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter;

  int n_chk  = 0;
  int n_fail = 0;

  seq_op_controller #(
    .WIDTH (WIDTH),
    .OPC_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .opc_code (opc_code),
    .lsb      (lsb),
    .neg      (neg),
    .control  (control),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter     (iter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] mul_pat;
    logic       seen;
    int         cyc;
    mul_pat  = 8'b1000_1101;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    opc_code = 2'd0;
    lsb      = 1'b0;
    neg      = 1'b0;
    #3;
    check("rst_ctrl", 32'(control), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_iter", 32'(iter), 32'h0);
    #9 rst = 1'b0;
    step;

    // MUL with lsb pattern 1,0,1,1,0,0,0,1
    start = 1'b1; opc_code = 2'd0;
    step;
    start = 1'b0; #1;
    check("mul_load", 32'(control), C_LOAD);
    check("mul_load_busy", 32'(busy), 32'h1);
    for (int k = 0; k < WIDTH; k++) begin
      step;
      lsb = mul_pat[k]; #1;
      check("mul_exec", 32'(control), C_SHIFT | (mul_pat[k] ? C_ADD : 32'h0));
      check("mul_iter", 32'(iter), 32'(k));
    end
    step; lsb = 1'b0; #1;
    check("mul_done", 32'(done), 32'h1);
    check("mul_err", 32'(err), 32'h0);
    check("mul_iter_done", 32'(iter), 32'(WIDTH));
    check("mul_done_busy", 32'(busy), 32'h0);
    check("mul_done_ctrl", 32'(control), 32'h0);
    step; #1;
    check("mul_idle_done", 32'(done), 32'h0);

    // DIV with neg alternating 1,0
    start = 1'b1; opc_code = 2'd1;
    step;
    start = 1'b0; #1;
    check("div_load", 32'(control), C_LOAD);
    for (int k = 0; k < WIDTH; k++) begin
      step; #1;
      check("div_exec", 32'(control), C_DIVX);
      step;
      neg = (k % 2 == 0); #1;
      check("div_fix", 32'(control), neg ? C_REST : C_QBIT);
      check("div_fix_iter", 32'(iter), 32'(k));
    end
    step; neg = 1'b0; #1;
    check("div_done", 32'(done), 32'h1);
    check("div_iter", 32'(iter), 32'(WIDTH));
    check("div_err", 32'(err), 32'h0);
    step;

    // Illegal opcode, then ADD clears err
    start = 1'b1; opc_code = 2'd3;
    step;
    start = 1'b0; #1;
    check("ill_load", 32'(control), C_LOAD);
    step; #1;
    check("ill_done", 32'(done), 32'h1);
    check("ill_err", 32'(err), 32'h1);
    check("ill_busy", 32'(busy), 32'h0);
    step; #1;
    check("ill_idle_err", 32'(err), 32'h0);
    start = 1'b1; opc_code = 2'd2;
    step;
    start = 1'b0; #1;
    check("add_load", 32'(control), C_LOAD);
    step; #1;
    check("add_exec", 32'(control), C_ADD);
    step; #1;
    check("add_done", 32'(done), 32'h1);
    check("add_err", 32'(err), 32'h0);
    step;

    // Async reset in the middle of a MUL at iter=3
    start = 1'b1; opc_code = 2'd0;
    step;
    start = 1'b0;
    for (int k = 0; k < 4; k++) step;
    #1;
    check("rmid_iter_pre", 32'(iter), 32'h3);
    rst = 1'b1; #1;
    check("rmid_ctrl", 32'(control), 32'h0);
    check("rmid_busy", 32'(busy), 32'h0);
    check("rmid_iter", 32'(iter), 32'h0);
    check("rmid_done", 32'(done), 32'h0);
    step;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step;
      if (done || busy) seen = 1'b1;
    end
    check("rmid_no_done", 32'(seen), 32'h0);

    // DIV aborted at iter=4 while start is held high
    start = 1'b1; opc_code = 2'd1;
    step; #1;
    check("abt_load", 32'(control), C_LOAD);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step; #1;
      if (control.load_a) seen = 1'b1;
    end
    step; #1;
    check("abt_no_reload", 32'(seen), 32'h0);
    check("abt_iter", 32'(iter), 32'h4);
    check("abt_exec", 32'(control), C_DIVX);
    abort = 1'b1;
    step;
    abort = 1'b0; start = 1'b0; #1;
    check("abt_busy", 32'(busy), 32'h0);
    check("abt_ctrl", 32'(control), 32'h0);
    check("abt_done", 32'(done), 32'h0);
    seen = 1'b0;
    repeat (4) begin
      step;
      if (done || busy) seen = 1'b1;
    end
    check("abt_quiet", 32'(seen), 32'h0);
    start = 1'b1; abort = 1'b1;
    step;
    start = 1'b0; abort = 1'b0; #1;
    check("abt_start_idle", 32'(busy), 32'h0);

    // ADD then MUL back-to-back with start held across DONE
    start = 1'b1; opc_code = 2'd2;
    step;
    opc_code = 2'd0; #1;
    check("b2b_load", 32'(control), C_LOAD);
    step; #1;
    check("b2b_add_exec", 32'(control), C_ADD);
    step; #1;
    check("b2b_add_done", 32'(done), 32'h1);
    step;
    start = 1'b0; #1;
    check("b2b_reload", 32'(control), C_LOAD);
    cyc = 1;
    while (!done && cyc < 50) begin
      step; cyc++;
    end
    check("b2b_mul_lat", 32'(cyc), 32'(WIDTH + 2));
    check("b2b_mul_iter", 32'(iter), 32'(WIDTH));
    check("b2b_mul_err", 32'(err), 32'h0);
    step;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
